// File: rtl/cavlc_nc_line_ctrl.sv
// cavlc_nc_line_ctrl
//   Computes the CAVLC nC (predicted total_coeff) for the 4x4 luma and
//   chroma AC blocks of the current MB. At MB start it fetches the top
//   neighbour line entry from the top-line RAM. At MB end it writes the
//   current MB bottom row back to that RAM. The left neighbour column and
//   the current MB per-block counts are kept in registers.
//
// Optional feature macro: CAVLC_NC_CONSTRAINED_EN
//   When defined, the inputs left_avail_i and top_avail_i are added. They
//   gate neighbour availability at slice boundaries. When top_avail_i is 0
//   the RAM fetch is skipped.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   mb_start_i          MB start pulse (IDLE only), with mb_x_i / mb_y_i
//   top_rdy_o           high while nC queries are accepted
//   nc_req_i            nC query strobe, with nc_type_i / nc_idx_i
//   nc_o, nc_vld_o      registered nC result and its valid flag
//   tc_we_i             store total_coeff tc_val_i for tc_type_i / tc_idx_i
//   mb_done_i           MB end pulse (READY only), triggers write-back
//   wb_done_o           pulse while the write-back is issued
//   ram_rd_o/raddr/rdata top-line RAM read port (1-cycle read latency)
//   ram_we_o/waddr/wdata top-line RAM write port
module cavlc_nc_line_ctrl #(
   parameter int unsigned MB_X_W = 7,
   parameter int unsigned MB_Y_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mb_start_i,
   input  logic [MB_X_W-1:0] mb_x_i,
   input  logic [MB_Y_W-1:0] mb_y_i,
`ifdef CAVLC_NC_CONSTRAINED_EN
   input  logic              left_avail_i,
   input  logic              top_avail_i,
`endif
   output logic              top_rdy_o,
   input  logic              nc_req_i,
   input  logic [1:0]        nc_type_i,
   input  logic [3:0]        nc_idx_i,
   output logic [4:0]        nc_o,
   output logic              nc_vld_o,
   input  logic              tc_we_i,
   input  logic [1:0]        tc_type_i,
   input  logic [3:0]        tc_idx_i,
   input  logic [4:0]        tc_val_i,
   input  logic              mb_done_i,
   output logic              wb_done_o,
   output logic              ram_rd_o,
   output logic [6:0]        ram_raddr_o,
   input  logic [35:0]       ram_rdata_i,
   output logic              ram_we_o,
   output logic [6:0]        ram_waddr_o,
   output logic [35:0]       ram_wdata_o
);

   typedef enum logic [2:0] {IDLE, RD, LAT, READY, WB} state_t;
   state_t state, state_nx;

   logic [MB_X_W-1:0] mb_x_q;
   logic              left_av, top_av;
   logic              left_av_nx, top_av_nx;

   logic [4:0] cur_luma  [16];
   logic [3:0] cur_cb    [4];
   logic [3:0] cur_cr    [4];
   logic [4:0] top_luma  [4];
   logic [3:0] top_cb    [2];
   logic [3:0] top_cr    [2];
   logic [4:0] left_luma [4];
   logic [3:0] left_cb   [2];
   logic [3:0] left_cr   [2];

   // Only the derived availability of the row index is needed later.
   always_comb begin
`ifdef CAVLC_NC_CONSTRAINED_EN
      left_av_nx = (mb_x_i != '0) && left_avail_i;
      top_av_nx  = (mb_y_i != '0) && top_avail_i;
`else
      left_av_nx = (mb_x_i != '0);
      top_av_nx  = (mb_y_i != '0);
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx    = state;
      top_rdy_o   = 1'b0;
      ram_rd_o    = 1'b0;
      ram_raddr_o = '0;
      ram_we_o    = 1'b0;
      ram_waddr_o = '0;
      ram_wdata_o = '0;
      wb_done_o   = 1'b0;
      case (state)
         IDLE: if (mb_start_i) state_nx = top_av_nx ? RD : READY;
         RD: begin
            ram_rd_o    = 1'b1;
            ram_raddr_o = 7'(mb_x_q);
            state_nx    = LAT;
         end
         LAT: state_nx = READY;
         READY: begin
            top_rdy_o = 1'b1;
            if (mb_done_i) state_nx = WB;
         end
         WB: begin
            ram_we_o    = 1'b1;
            ram_waddr_o = 7'(mb_x_q);
            ram_wdata_o = {cur_cr[3], cur_cr[2], cur_cb[3], cur_cb[2],
                           cur_luma[15], cur_luma[14], cur_luma[13], cur_luma[12]};
            wb_done_o   = 1'b1;
            state_nx    = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Neighbour selection and nC arithmetic for the current query.
   logic [4:0] na, nb, nc_calc;
   logic       a_av, b_av;
   logic [5:0] sum;
   logic       is_cr;
   logic [1:0] cidx;

   always_comb begin
      na    = '0;
      nb    = '0;
      a_av  = 1'b0;
      b_av  = 1'b0;
      is_cr = (nc_type_i == 2'd2);
      cidx  = nc_idx_i[1:0];
      case (nc_type_i)
         2'd0: begin
            if (nc_idx_i[1:0] != 2'd0) begin
               na   = cur_luma[nc_idx_i - 4'd1];
               a_av = 1'b1;
            end else begin
               na   = left_luma[nc_idx_i[3:2]];
               a_av = left_av;
            end
            if (nc_idx_i[3:2] != 2'd0) begin
               nb   = cur_luma[nc_idx_i - 4'd4];
               b_av = 1'b1;
            end else begin
               nb   = top_luma[nc_idx_i[1:0]];
               b_av = top_av;
            end
         end
         2'd1, 2'd2: begin
            if (cidx[0]) begin
               na   = {1'b0, is_cr ? cur_cr[cidx - 2'd1] : cur_cb[cidx - 2'd1]};
               a_av = 1'b1;
            end else begin
               na   = {1'b0, is_cr ? left_cr[cidx[1]] : left_cb[cidx[1]]};
               a_av = left_av;
            end
            if (cidx[1]) begin
               nb   = {1'b0, is_cr ? cur_cr[cidx - 2'd2] : cur_cb[cidx - 2'd2]};
               b_av = 1'b1;
            end else begin
               nb   = {1'b0, is_cr ? top_cr[cidx[0]] : top_cb[cidx[0]]};
               b_av = top_av;
            end
         end
         default: ;
      endcase
      sum = {1'b0, na} + {1'b0, nb} + 6'd1;
      if (a_av && b_av) nc_calc = sum[5:1];
      else if (a_av)    nc_calc = na;
      else if (b_av)    nc_calc = nb;
      else              nc_calc = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mb_x_q   <= '0;
         left_av  <= 1'b0;
         top_av   <= 1'b0;
         nc_o     <= '0;
         nc_vld_o <= 1'b0;
         for (int unsigned i = 0; i < 16; i++) cur_luma[i] <= '0;
         for (int unsigned i = 0; i < 4; i++) begin
            cur_cb[i]    <= '0;
            cur_cr[i]    <= '0;
            top_luma[i]  <= '0;
            left_luma[i] <= '0;
         end
         for (int unsigned i = 0; i < 2; i++) begin
            top_cb[i]  <= '0;
            top_cr[i]  <= '0;
            left_cb[i] <= '0;
            left_cr[i] <= '0;
         end
      end else begin
         nc_vld_o <= 1'b0;
         case (state)
            IDLE: if (mb_start_i) begin
               mb_x_q  <= mb_x_i;
               left_av <= left_av_nx;
               top_av  <= top_av_nx;
               if (!top_av_nx) begin
                  for (int unsigned i = 0; i < 4; i++) top_luma[i] <= '0;
                  for (int unsigned i = 0; i < 2; i++) begin
                     top_cb[i] <= '0;
                     top_cr[i] <= '0;
                  end
               end
            end
            LAT: begin
               for (int unsigned i = 0; i < 4; i++) top_luma[i] <= ram_rdata_i[i*5 +: 5];
               for (int unsigned i = 0; i < 2; i++) begin
                  top_cb[i] <= ram_rdata_i[20 + i*4 +: 4];
                  top_cr[i] <= ram_rdata_i[28 + i*4 +: 4];
               end
            end
            READY: begin
               // Query is evaluated from the pre-write register values.
               if (nc_req_i) begin
                  nc_o     <= nc_calc;
                  nc_vld_o <= 1'b1;
               end
               if (tc_we_i) begin
                  case (tc_type_i)
                     2'd0:    cur_luma[tc_idx_i]    <= tc_val_i;
                     2'd1:    cur_cb[tc_idx_i[1:0]] <= tc_val_i[3:0];
                     2'd2:    cur_cr[tc_idx_i[1:0]] <= tc_val_i[3:0];
                     default: ;
                  endcase
               end
            end
            WB: begin
               for (int unsigned r = 0; r < 4; r++) left_luma[r] <= cur_luma[r*4 + 3];
               for (int unsigned r = 0; r < 2; r++) begin
                  left_cb[r] <= cur_cb[r*2 + 1];
                  left_cr[r] <= cur_cr[r*2 + 1];
               end
               for (int unsigned i = 0; i < 16; i++) cur_luma[i] <= '0;
               for (int unsigned i = 0; i < 4; i++) begin
                  cur_cb[i] <= '0;
                  cur_cr[i] <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cavlc_nc_line_ctrl.sv
module tb_cavlc_nc_line_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mb_start_i = 1'b0;
   logic [6:0]  mb_x_i = '0;
   logic [7:0]  mb_y_i = '0;
`ifdef CAVLC_NC_CONSTRAINED_EN
   logic        left_avail_i = 1'b1;
   logic        top_avail_i = 1'b1;
`endif
   logic        top_rdy_o;
   logic        nc_req_i = 1'b0;
   logic [1:0]  nc_type_i = '0;
   logic [3:0]  nc_idx_i = '0;
   logic [4:0]  nc_o;
   logic        nc_vld_o;
   logic        tc_we_i = 1'b0;
   logic [1:0]  tc_type_i = '0;
   logic [3:0]  tc_idx_i = '0;
   logic [4:0]  tc_val_i = '0;
   logic        mb_done_i = 1'b0;
   logic        wb_done_o;
   logic        ram_rd_o;
   logic [6:0]  ram_raddr_o;
   logic [35:0] ram_rdata_i = '0;
   logic        ram_we_o;
   logic [6:0]  ram_waddr_o;
   logic [35:0] ram_wdata_o;

   int tests = 0;
   int failed = 0;

   always #5 clk = ~clk;

   cavlc_nc_line_ctrl #(.MB_X_W(7), .MB_Y_W(8)) dut (
      .clk(clk), .rst(rst),
      .mb_start_i(mb_start_i), .mb_x_i(mb_x_i), .mb_y_i(mb_y_i),
`ifdef CAVLC_NC_CONSTRAINED_EN
      .left_avail_i(left_avail_i), .top_avail_i(top_avail_i),
`endif
      .top_rdy_o(top_rdy_o),
      .nc_req_i(nc_req_i), .nc_type_i(nc_type_i), .nc_idx_i(nc_idx_i),
      .nc_o(nc_o), .nc_vld_o(nc_vld_o),
      .tc_we_i(tc_we_i), .tc_type_i(tc_type_i), .tc_idx_i(tc_idx_i), .tc_val_i(tc_val_i),
      .mb_done_i(mb_done_i), .wb_done_o(wb_done_o),
      .ram_rd_o(ram_rd_o), .ram_raddr_o(ram_raddr_o), .ram_rdata_i(ram_rdata_i),
      .ram_we_o(ram_we_o), .ram_waddr_o(ram_waddr_o), .ram_wdata_o(ram_wdata_o)
   );

   task automatic check(input string tag, input logic [35:0] act, input logic [35:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_mb(input logic [6:0] x, input logic [7:0] y);
      mb_start_i = 1'b1;
      mb_x_i     = x;
      mb_y_i     = y;
      tick();
      mb_start_i = 1'b0;
   endtask

   task automatic write_tc(input logic [1:0] t, input logic [3:0] idx, input logic [4:0] v);
      tc_we_i   = 1'b1;
      tc_type_i = t;
      tc_idx_i  = idx;
      tc_val_i  = v;
      tick();
      tc_we_i   = 1'b0;
   endtask

   task automatic query(input string tag, input logic [1:0] t, input logic [3:0] idx,
                        input logic [4:0] exp);
      nc_req_i  = 1'b1;
      nc_type_i = t;
      nc_idx_i  = idx;
      tick();
      nc_req_i  = 1'b0;
      check({tag, "_vld"}, 36'(nc_vld_o), 36'd1);
      check(tag, 36'(nc_o), 36'(exp));
   endtask

   task automatic wait_ready(input string tag);
      int n;
      n = 0;
      while (!top_rdy_o && n < 8) begin
         tick();
         n++;
      end
      check(tag, 36'(top_rdy_o), 36'd1);
   endtask

   initial begin
      logic [35:0] exp_wb;

      // Reset state
      repeat (2) tick();
      check("rst_top_rdy", 36'(top_rdy_o), 36'd0);
      check("rst_nc_vld", 36'(nc_vld_o), 36'd0);
      check("rst_nc", 36'(nc_o), 36'd0);
      check("rst_ram_rd", 36'(ram_rd_o), 36'd0);
      check("rst_ram_we", 36'(ram_we_o), 36'd0);
      check("rst_wb_done", 36'(wb_done_o), 36'd0);
      rst = 1'b0;
      tick();

      // MB (0,0): all counts 3
      start_mb(7'd0, 8'd0);
      check("mb00_rdy_t1", 36'(top_rdy_o), 36'd1);
      check("mb00_no_rd", 36'(ram_rd_o), 36'd0);
      for (int i = 0; i < 16; i++) write_tc(2'd0, 4'(i), 5'd3);
      for (int i = 0; i < 4; i++) write_tc(2'd1, 4'(i), 5'd3);
      for (int i = 0; i < 4; i++) write_tc(2'd2, 4'(i), 5'd3);
      query("mb00_l0", 2'd0, 4'd0, 5'd0);
      query("mb00_rsv", 2'd3, 4'd5, 5'd0);
      query("mb00_l5", 2'd0, 4'd5, 5'd3);
      query("mb00_cr3", 2'd2, 4'd3, 5'd3);
      mb_done_i = 1'b1;
      tick();
      mb_done_i = 1'b0;
      exp_wb = {4'd3, 4'd3, 4'd3, 4'd3, 5'd3, 5'd3, 5'd3, 5'd3};
      check("mb00_we", 36'(ram_we_o), 36'd1);
      check("mb00_waddr", 36'(ram_waddr_o), 36'd0);
      check("mb00_wdata", ram_wdata_o, exp_wb);
      check("mb00_wb_done", 36'(wb_done_o), 36'd1);
      tick();
      check("mb00_idle_we", 36'(ram_we_o), 36'd0);
      check("mb00_idle_rdy", 36'(top_rdy_o), 36'd0);
      // Query outside READY is ignored; nc_o holds
      nc_req_i = 1'b1;
      nc_type_i = 2'd0;
      nc_idx_i = 4'd0;
      tick();
      nc_req_i = 1'b0;
      check("idle_q_vld", 36'(nc_vld_o), 36'd0);
      check("idle_q_hold", 36'(nc_o), 36'd3);
      // tc write outside READY is ignored
      write_tc(2'd0, 4'd0, 5'd9);

      // MB (1,0): left neighbours from MB (0,0)
      start_mb(7'd1, 8'd0);
      check("mb10_rdy_t1", 36'(top_rdy_o), 36'd1);
      query("mb10_l0", 2'd0, 4'd0, 5'd3);
      query("mb10_cb0", 2'd1, 4'd0, 5'd3);
      query("mb10_l4", 2'd0, 4'd4, 5'd2);
      mb_done_i = 1'b1;
      tick();
      mb_done_i = 1'b0;
      check("mb10_waddr", 36'(ram_waddr_o), 36'd1);
      check("mb10_wdata", ram_wdata_o, 36'd0);
      tick();

      // MB (0,1): top fetched from RAM
      ram_rdata_i = 36'h0_0000_0010;
      start_mb(7'd0, 8'd1);
      check("mb01_rd_t1", 36'(ram_rd_o), 36'd1);
      check("mb01_raddr_t1", 36'(ram_raddr_o), 36'd0);
      check("mb01_rdy_t1", 36'(top_rdy_o), 36'd0);
      tick();
      check("mb01_rdy_t2", 36'(top_rdy_o), 36'd0);
      check("mb01_rd_t2", 36'(ram_rd_o), 36'd0);
      tick();
      check("mb01_rdy_t3", 36'(top_rdy_o), 36'd1);
      query("mb01_l0", 2'd0, 4'd0, 5'd16);
      query("mb01_l1", 2'd0, 4'd1, 5'd0);
      write_tc(2'd0, 4'd3, 5'd16);
      mb_done_i = 1'b1;
      tick();
      mb_done_i = 1'b0;
      check("mb01_wdata", ram_wdata_o, 36'd0);
      tick();

      // MB (1,1): left row0=16, top x0=5
      ram_rdata_i = 36'h0_0000_0005;
      start_mb(7'd1, 8'd1);
      check("mb11_raddr", 36'(ram_raddr_o), 36'd1);
      wait_ready("mb11_rdy");
      query("mb11_l0", 2'd0, 4'd0, 5'd11);
      // Write and query in the same cycle
      tc_we_i = 1'b1; tc_type_i = 2'd0; tc_idx_i = 4'd0; tc_val_i = 5'd7;
      query("mb11_l0_wr", 2'd0, 4'd0, 5'd11);
      tc_we_i = 1'b0;
      query("mb11_l1", 2'd0, 4'd1, 5'd4);
      tc_we_i = 1'b1; tc_type_i = 2'd0; tc_idx_i = 4'd1; tc_val_i = 5'd9;
      query("mb11_l2_pre", 2'd0, 4'd2, 5'd0);
      tc_we_i = 1'b0;
      query("mb11_l2_post", 2'd0, 4'd2, 5'd5);
      // tc write coinciding with mb_done lands in the write-back
      tc_we_i = 1'b1; tc_type_i = 2'd0; tc_idx_i = 4'd15; tc_val_i = 5'd12;
      mb_done_i = 1'b1;
      tick();
      tc_we_i = 1'b0;
      mb_done_i = 1'b0;
      check("mb11_wdata", ram_wdata_o, 36'h0_0006_0000);
      tick();

      // Reset while in LAT
      ram_rdata_i = '0;
      start_mb(7'd2, 8'd1);
      tick();
      #2;
      rst = 1'b1;
      #1;
      check("rstlat_rd", 36'(ram_rd_o), 36'd0);
      check("rstlat_rdy", 36'(top_rdy_o), 36'd0);
      check("rstlat_nc", 36'(nc_o), 36'd0);
      check("rstlat_we", 36'(ram_we_o), 36'd0);
      tick();
      rst = 1'b0;
      tick();
      check("post_rst_we", 36'(ram_we_o), 36'd0);
      check("post_rst_rdy", 36'(top_rdy_o), 36'd0);
      start_mb(7'd0, 8'd0);
      check("post_rst_start", 36'(top_rdy_o), 36'd1);
      query("post_rst_l5", 2'd0, 4'd5, 5'd0);
      write_tc(2'd0, 4'd3, 5'd8);
      mb_done_i = 1'b1;
      tick();
      mb_done_i = 1'b0;
      tick();

`ifdef CAVLC_NC_CONSTRAINED_EN
      // Slice boundary: neither neighbour available despite coordinates
      left_avail_i = 1'b0;
      top_avail_i  = 1'b0;
      ram_rdata_i  = 36'hF_FFFF_FFFF;
      start_mb(7'd2, 8'd3);
      check("cons_no_rd", 36'(ram_rd_o), 36'd0);
      check("cons_rdy_t1", 36'(top_rdy_o), 36'd1);
      query("cons_l0", 2'd0, 4'd0, 5'd0);
      query("cons_l3", 2'd0, 4'd3, 5'd0);
      query("cons_cb0", 2'd1, 4'd0, 5'd0);
      mb_done_i = 1'b1;
      tick();
      mb_done_i = 1'b0;
      tick();
`endif

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule
